// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed signed FIR with one shared multiplier, a delay
// line per channel and a single coefficient bank loaded through a serial chain.
//
// state | meaning
// IDLE  | waiting for a sample; pending coefficient uploads are applied here
// MAC   | one product per cycle over TAPS taps of the latched channel
// OUT   | result held on ext_out until downstream accepts it
module fir_filter_mc #(
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int TAPS     = 4,
  parameter int CHANNELS = 2,
  parameter int OUTSHIFT = 8,
  parameter int CHBITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sde_in,
  input  logic                sd_in,
  output logic                sd_out,
  input  logic                ul_in,
  input  logic                dl_in,
  input  logic [DATABITS-1:0] ext_in,
  input  logic [CHBITS-1:0]   ext_ch_in,
  input  logic                extvalid_in,
  output logic                extready_out,
  output logic [DATABITS-1:0] ext_out,
  output logic [CHBITS-1:0]   ext_ch_out,
  output logic                extvalid_out,
  input  logic                extready_in
);
  localparam int KBITS = $clog2(TAPS);
  localparam int PW    = DATABITS + COEFBITS;
  localparam int ACCW  = PW + $clog2(TAPS);
  localparam int CW    = TAPS * COEFBITS;
  localparam logic signed [COEFBITS-1:0] COEF_ONE = COEFBITS'(1) << OUTSHIFT;
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DATABITS+1){1'b1}}, {(DATABITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                     state;
  logic                       rdy_q;
  logic [CHBITS-1:0]          ch_q;
  logic [KBITS-1:0]           k_q;
  logic signed [ACCW-1:0]     acc;
  logic signed [DATABITS-1:0] x [CHANNELS][TAPS];

  logic [CW-1:0]              chain;
  logic [CW-1:0]              bank_flat;
  logic signed [COEFBITS-1:0] coef [TAPS];
  logic                       ul_pend;
  logic                       ul_apply;

  logic signed [DATABITS-1:0] x_sel;
  logic signed [COEFBITS-1:0] c_sel;
  logic signed [PW-1:0]       prod;
  logic signed [ACCW-1:0]     acc_sum;
  logic signed [ACCW-1:0]     acc_shr;
  logic [DATABITS-1:0]        sat_val;

  // Uploads only land while idle, so a computation never sees a mixed bank.
  assign ul_apply     = (state == IDLE) && (ul_in || ul_pend);
  assign extready_out = rdy_q && !ul_apply;
  assign sd_out       = chain[CW-1];

  always_comb begin
    bank_flat = '0;
    for (int k = 0; k < TAPS; k++) bank_flat[k*COEFBITS +: COEFBITS] = coef[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain   <= '0;
      ul_pend <= 1'b0;
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_ONE : '0;
    end else begin
      if (dl_in)       chain <= bank_flat;
      else if (sde_in) chain <= {chain[CW-2:0], sd_in};
      if (ul_apply) begin
        for (int k = 0; k < TAPS; k++) coef[k] <= chain[k*COEFBITS +: COEFBITS];
        ul_pend <= 1'b0;
      end else if (ul_in) begin
        ul_pend <= 1'b1;
      end
    end
  end

  assign x_sel = x[ch_q][k_q];
  assign c_sel = coef[k_q];
  assign prod  = PW'(x_sel) * PW'(c_sel);

  always_comb begin
    acc_sum = acc + ACCW'(prod);
    acc_shr = acc_sum >>> OUTSHIFT;
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[DATABITS-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[DATABITS-1:0];
    else                        sat_val = acc_shr[DATABITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      ch_q         <= '0;
      k_q          <= '0;
      acc          <= '0;
      ext_out      <= '0;
      ext_ch_out   <= '0;
      extvalid_out <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) x[c][k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          // Out-of-range tags are consumed and dropped without touching any line.
          if (extvalid_in && extready_out && (int'(ext_ch_in) < CHANNELS)) begin
            x[ext_ch_in][0] <= ext_in;
            for (int k = 1; k < TAPS; k++) x[ext_ch_in][k] <= x[ext_ch_in][k-1];
            ch_q  <= ext_ch_in;
            acc   <= '0;
            k_q   <= '0;
            rdy_q <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          k_q <= k_q + KBITS'(1);
          if (k_q == KBITS'(TAPS-1)) begin
            ext_out      <= sat_val;
            ext_ch_out   <= ch_q;
            extvalid_out <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (extready_in) begin
            extvalid_out <= 1'b0;
            rdy_q        <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Testbench for fir_filter_mc: scenario tasks checked against a plain-arithmetic
// model of the coefficient bank and per-channel sample histories.
module tb_fir_filter_mc;
  localparam int DW   = 16;
  localparam int CWB  = 16;
  localparam int TAPS = 4;
  localparam int CHN  = 2;
  localparam int OS   = 8;
  localparam int CHB  = 1;
  localparam int CW   = TAPS * CWB;
  localparam int LAT  = TAPS + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sde_in = 1'b0, sd_in = 1'b0, ul_in = 1'b0, dl_in = 1'b0;
  logic [DW-1:0]  ext_in = '0;
  logic [CHB-1:0] ext_ch_in = '0;
  logic           extvalid_in = 1'b0, extready_in = 1'b1;
  logic           sd_out, extready_out, extvalid_out;
  logic [DW-1:0]  ext_out;
  logic [CHB-1:0] ext_ch_out;

  int vectors = 0;
  int miscompares = 0;

  int mcoef [TAPS];
  int stage [TAPS];
  int hist [CHN][TAPS];

  fir_filter_mc #(.DATABITS(DW), .COEFBITS(CWB), .TAPS(TAPS), .CHANNELS(CHN), .OUTSHIFT(OS)) dut (
    .clk(clk), .rst(rst), .sde_in(sde_in), .sd_in(sd_in), .sd_out(sd_out),
    .ul_in(ul_in), .dl_in(dl_in), .ext_in(ext_in), .ext_ch_in(ext_ch_in),
    .extvalid_in(extvalid_in), .extready_out(extready_out), .ext_out(ext_out),
    .ext_ch_out(ext_ch_out), .extvalid_out(extvalid_out), .extready_in(extready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  // Reference model: bank copy, histories, sum of products, floor shift, clamp.
  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) mcoef[k] = (k == 0) ? (1 << OS) : 0;
    for (int c = 0; c < CHN; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
  endfunction

  function automatic int model_push(input int ch, input int d);
    longint s;
    for (int k = TAPS-1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = d;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(hist[ch][k]) * longint'(mcoef[k]);
    s = s >>> OS;
    if (s > longint'(32767)) s = 32767;
    else if (s < longint'(-32768)) s = -32768;
    return int'(s);
  endfunction

  function automatic logic [CW-1:0] pack_stage();
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) v[k*CWB +: CWB] = CWB'(stage[k]);
    return v;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sde_in = 0; sd_in = 0; ul_in = 0; dl_in = 0;
    extvalid_in = 0; ext_in = '0; ext_ch_in = '0; extready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic shift_chain(input logic [CW-1:0] v);
    for (int i = CW-1; i >= 0; i--) begin
      sde_in = 1'b1; sd_in = v[i];
      @(posedge clk); #1;
    end
    sde_in = 1'b0; sd_in = 1'b0;
  endtask

  task automatic load_coefs();
    shift_chain(pack_stage());
    ul_in = 1'b1;
    @(posedge clk); #1;
    ul_in = 1'b0;
    for (int k = 0; k < TAPS; k++) mcoef[k] = stage[k];
  endtask

  // Drives one sample, returns what the DUT produced and the accept-to-valid latency.
  task automatic run_sample(input int ch, input int d, input int ul_at,
                            output logic [DW-1:0] got, output logic [CHB-1:0] gch, output int lat);
    int n;
    n = 0;
    while (!extready_out && n < 50) begin @(posedge clk); #1; n++; end
    ext_in = DW'(d); ext_ch_in = CHB'(ch); extvalid_in = 1'b1;
    @(posedge clk); #1;
    extvalid_in = 1'b0;
    lat = 1;
    while (!extvalid_out && lat < 40) begin
      ul_in = (lat == ul_at);
      @(posedge clk); #1;
      ul_in = 1'b0;
      lat++;
    end
    got = ext_out; gch = ext_ch_out;
    if (!extvalid_out) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({extvalid_out, extready_out, sd_out} !== 3'b000 || ext_out !== '0 || ext_ch_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b ready=%b sd=%b out=%0h ch=%0d, expected all 0",
               extvalid_out, extready_out, sd_out, ext_out, ext_ch_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (extready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: extready_out=%b, expected 1 in IDLE", extready_out);
    end
  endtask

  task automatic test_identity();
    int din [3];
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp;
    din[0] = 100; din[1] = -7; din[2] = 32767;
    for (int i = 0; i < 3; i++) begin
      run_sample(0, din[i], -1, got, gch, lat);
      exp = model_push(0, din[i]);
      vectors++;
      if (got !== DW'(exp) || got !== DW'(din[i]) || gch !== 1'b0 || lat != LAT) begin
        miscompares++;
        $display("FAIL identity: in=%0d got %0d ch%0d lat %0d, expected %0d ch0 lat %0d",
                 din[i], $signed(got), gch, lat, exp, LAT);
      end
    end
  endtask

  task automatic test_serial_load();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp;
    do_reset();
    for (int k = 0; k < TAPS; k++) stage[k] = 64;
    load_coefs();
    for (int i = 0; i < 4; i++) begin
      run_sample(0, 400, -1, got, gch, lat);
      exp = model_push(0, 400);
      vectors++;
      if (got !== DW'(exp) || got !== DW'(100*(i+1)) || gch !== 1'b0 || lat != LAT) begin
        miscompares++;
        $display("FAIL serial_load: step %0d got %0d ch%0d lat %0d, expected %0d lat %0d",
                 i, $signed(got), gch, lat, exp, LAT);
      end
    end
  endtask

  task automatic test_interleave();
    int chs [4]; int dat [4];
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp;
    chs[0] = 0; chs[1] = 1; chs[2] = 0; chs[3] = 1;
    dat[0] = 400; dat[1] = 800; dat[2] = 400; dat[3] = 800;
    do_reset();
    for (int k = 0; k < TAPS; k++) stage[k] = 64;
    load_coefs();
    for (int i = 0; i < 4; i++) begin
      run_sample(chs[i], dat[i], -1, got, gch, lat);
      exp = model_push(chs[i], dat[i]);
      vectors++;
      if (got !== DW'(exp) || gch !== CHB'(chs[i]) || lat != LAT) begin
        miscompares++;
        $display("FAIL interleave: step %0d got %0d ch%0d lat %0d, expected %0d ch%0d",
                 i, $signed(got), gch, lat, exp, chs[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp, d;
    do_reset();
    for (int k = 0; k < TAPS; k++) stage[k] = 32767;
    load_coefs();
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? 32767 : -32768;
      run_sample(1, d, -1, got, gch, lat);
      exp = model_push(1, d);
      vectors++;
      if (got !== DW'(exp) || gch !== 1'b1 || lat != LAT) begin
        miscompares++;
        $display("FAIL saturation: step %0d got %0d lat %0d, expected %0d", i, $signed(got), lat, exp);
      end
    end
    vectors++;
    if (got !== 16'h8000) begin
      miscompares++;
      $display("FAIL saturation_min: got %0d, expected -32768", $signed(got));
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held; logic [CHB-1:0] hch; int n, exp, d, bad, extra;
    d = rnd16();
    extready_in = 1'b0;
    n = 0;
    while (!extready_out && n < 50) begin @(posedge clk); #1; n++; end
    ext_in = DW'(d); ext_ch_in = 1'b1; extvalid_in = 1'b1;
    @(posedge clk); #1;
    extvalid_in = 1'b0;
    n = 0;
    while (!extvalid_out && n < 40) begin @(posedge clk); #1; n++; end
    exp = model_push(1, d);
    held = ext_out; hch = ext_ch_out;
    vectors++;
    if (extvalid_out !== 1'b1 || held !== DW'(exp) || hch !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_result: valid=%b got %0d ch%0d, expected %0d ch1", extvalid_out, $signed(held), hch, exp);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ext_out !== held || ext_ch_out !== hch || extvalid_out !== 1'b1 || extready_out !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles while stalled, expected 0", bad);
    end
    extready_in = 1'b1;
    @(posedge clk); #1;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (extvalid_out !== 1'b0) extra++;
      @(posedge clk); #1;
    end
    vectors++;
    if (extra != 0 || extready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: %0d extra valid cycles, ready=%b, expected 0 and 1", extra, extready_out);
    end
  endtask

  task automatic test_ul_during_mac();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp;
    do_reset();
    for (int k = 0; k < TAPS; k++) stage[k] = 64;
    load_coefs();
    stage[0] = 256; stage[1] = 128; stage[2] = 0; stage[3] = 0;
    shift_chain(pack_stage());
    run_sample(0, 400, 2, got, gch, lat);
    exp = model_push(0, 400);
    vectors++;
    if (got !== DW'(exp) || lat != LAT) begin
      miscompares++;
      $display("FAIL ul_old_coefs: got %0d lat %0d, expected %0d lat %0d", $signed(got), lat, exp, LAT);
    end
    vectors++;
    if (extready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ul_apply_ready: extready_out=%b during pending upload, expected 0", extready_out);
    end
    for (int k = 0; k < TAPS; k++) mcoef[k] = stage[k];
    run_sample(0, 400, -1, got, gch, lat);
    exp = model_push(0, 400);
    vectors++;
    if (got !== DW'(exp) || got !== DW'(600)) begin
      miscompares++;
      $display("FAIL ul_new_coefs: got %0d, expected %0d", $signed(got), exp);
    end
  endtask

  task automatic test_download();
    logic [CW-1:0] expv, junk;
    int bad;
    for (int k = 0; k < TAPS; k++) stage[k] = rnd16();
    load_coefs();
    junk = {$urandom, $urandom};
    shift_chain(junk);
    expv = pack_stage();
    dl_in = 1'b1; sde_in = 1'b1; sd_in = 1'b1;
    @(posedge clk); #1;
    dl_in = 1'b0; sde_in = 1'b0; sd_in = 1'b0;
    bad = 0;
    for (int i = CW-1; i >= 0; i--) begin
      vectors++;
      if (sd_out !== expv[i]) begin
        miscompares++;
        $display("FAIL download_bit: bit %0d got %b, expected %b", i, sd_out, expv[i]);
      end
      sde_in = 1'b1;
      @(posedge clk); #1;
    end
    sde_in = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp, d, seen;
    for (int k = 0; k < TAPS; k++) stage[k] = 64;
    load_coefs();
    ext_in = 16'd1234; ext_ch_in = 1'b0; extvalid_in = 1'b1;
    @(posedge clk); #1;
    extvalid_in = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (extvalid_out !== 1'b0 || extready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_mac: valid=%b ready=%b under reset, expected 0 0", extvalid_out, extready_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (extvalid_out !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_no_output: %0d valid cycles after reset, expected 0", seen);
    end
    d = rnd16();
    run_sample(0, d, -1, got, gch, lat);
    exp = model_push(0, d);
    vectors++;
    if (got !== DW'(exp) || got !== DW'(d) || lat != LAT) begin
      miscompares++;
      $display("FAIL rst_identity: got %0d lat %0d, expected %0d lat %0d", $signed(got), lat, exp, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp, ch, d;
    for (int i = 0; i < 6; i++) begin
      ch = int'($urandom_range(0, CHN-1));
      d = rnd16();
      run_sample(ch, d, -1, got, gch, lat);
      exp = model_push(ch, d);
      vectors++;
      if (got !== DW'(exp) || gch !== CHB'(ch) || lat != LAT || extready_out !== 1'b1) begin
        miscompares++;
        $display("FAIL back_to_back: step %0d got %0d ch%0d lat %0d ready %b, expected %0d ch%0d lat %0d ready 1",
                 i, $signed(got), gch, lat, extready_out, exp, ch, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] got; logic [CHB-1:0] gch; int lat, exp, ch, d;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TAPS; k++)
        stage[k] = (r == 2) ? rnd16() : int'($urandom_range(0, 1023)) - 512;
      load_coefs();
      for (int i = 0; i < 12; i++) begin
        ch = int'($urandom_range(0, CHN-1));
        d = rnd16();
        run_sample(ch, d, -1, got, gch, lat);
        exp = model_push(ch, d);
        vectors++;
        if (got !== DW'(exp) || gch !== CHB'(ch) || lat != LAT) begin
          miscompares++;
          $display("FAIL random: round %0d step %0d ch%0d in %0d got %0d ch%0d lat %0d, expected %0d",
                   r, i, ch, d, $signed(got), gch, lat, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_serial_load();
    test_interleave();
    test_saturation();
    test_backpressure();
    test_ul_during_mac();
    test_download();
    test_reset_mid_mac();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fir_filter_mc.md
Name: fir_filter_mc

Overview:
- Parametrised multi-channel successor to the single-channel filter unit.
- Time-multiplexed signed FIR: one shared multiplier, one independent delay line per channel, one coefficient bank shared by all channels.
- Coefficients are loaded through the serial shift/upload/download interface driven by the I2C slave.
- Samples enter and leave on valid/ready streams tagged with a channel index.

Parameters:
- DATABITS, 16, sample width, signed two's complement.
- COEFBITS, 16, coefficient width, signed.
- TAPS, 4, filter length, >=2.
- CHANNELS, 2, number of independent delay lines, >=1.
- OUTSHIFT, 8, arithmetic right shift applied to accumulator; must be < COEFBITS-1.
- CHBITS, max(1,$clog2(CHANNELS)), channel tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- sde_in  in  1  serial shift enable.
- sd_in  in  1  serial data in.
- sd_out  out  1  serial data out = MSB of shift chain.
- ul_in  in  1  upload pulse: shift chain -> coefficient bank.
- dl_in  in  1  download pulse: coefficient bank -> shift chain.
- ext_in  in  DATABITS  input sample.
- ext_ch_in  in  CHBITS  input channel tag.
- extvalid_in  in  1  input valid.
- extready_out  out  1  input ready.
- ext_out  out  DATABITS  filtered sample.
- ext_ch_out  out  CHBITS  channel tag of ext_out.
- extvalid_out  out  1  output valid.
- extready_in  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, active-high rst):
  - All outputs 0, including extready_out.
  - FSM goes to IDLE; delay lines and shift chain cleared.
  - Coefficient bank set to c[0]=2**OUTSHIFT, all others 0, so the filter is identity/pass-through.
  - Reset mid-operation abandons the computation with no output.
- Shift chain:
  - TAPS*COEFBITS bits; chain MSB is c[TAPS-1] MSB, chain LSB is c[0] LSB.
  - sde_in=1: shift left one bit per cycle, sd_in enters the LSB.
  - dl_in=1: chain <= bank, overriding sde_in in the same cycle.
  - ul_in=1 in IDLE: bank <= chain, effective on the next cycle.
  - ul_in outside IDLE: set upload-pending; apply on entry to IDLE so no computation ever mixes old and new coefficients.
  - ul_in and dl_in in the same cycle: swap.
- FSM states:
  - IDLE: extready_out=1 unless an upload is being applied this cycle. On extvalid_in&&extready_out, shift ext_in into delay line x[ext_ch_in] (x[0] newest), latch the channel, clear acc, go to MAC.
  - Out-of-range tag (ext_ch_in>=CHANNELS): sample consumed and discarded, stay IDLE, no output.
  - MAC: k=0..TAPS-1, one product per cycle, acc += x[ch][k]*c[k]. After TAPS cycles go to OUT.
  - OUT: ext_out=sat(acc>>>OUTSHIFT), ext_ch_out=ch, extvalid_out=1. Values are held stable until extready_in=1; the handshake cycle returns to IDLE, and extvalid_out drops the following cycle.
- Arithmetic:
  - acc width is DATABITS+COEFBITS+$clog2(TAPS); full signed products.
  - Shift is arithmetic, truncating toward minus infinity.
  - Saturation clamps to [-2**(DATABITS-1), 2**(DATABITS-1)-1].
- Timing:
  - Accept at cycle 0, extvalid_out=1 at cycle TAPS+1.
  - Throughput is one sample per TAPS+2 cycles with extready_in tied high.
  - extready_out=0 throughout MAC and OUT.
- Channels are fully independent: a sample on one channel never alters another channel's delay line.

Test Plan:
- Post-reset identity: ch0 inputs 100, -7, 32767 -> outputs 100, -7, 32767 on ch0, each at accept+5 cycles.
- Serial load of all coefficients=64 (64 sde cycles, ul pulse), then 400,400,400,400 on ch0 -> outputs 100,200,300,400.
- Interleaved channels with coefs=64: ch0 400, ch1 800, ch0 400, ch1 800 -> ch0 100, ch1 200, ch0 200, ch1 400.
- Saturation with all coefs=32767:
  - Input 32767 x4 -> output 32767.
  - Input -32768 x4 -> output -32768.
- Backpressure: extready_in=0 for 10 cycles in OUT -> ext_out and ext_ch_out stable, extready_out=0, single transfer when released.
- ul_in during MAC -> current result uses old coefficients, next sample uses new.
- dl_in followed by 64 sde cycles -> sd_out returns the bank contents MSB-first.
- rst asserted mid-MAC -> extvalid_out=0 immediately, identity coefficients restored.
